dma_writeback: RTL

Write-back DMA engine for the user project area. It takes the result stream from the accelerator, buffers it in a small FIFO, and writes it into the user-area DRAM as Wishbone write bursts. It is the write-direction counterpart of the existing read DMA, which fetches DRAM data into the accelerator. The CPU configures it through three Wishbone CSRs on the Caravel slave bus, and it raises an interrupt when the transfer completes.

---
 rtl/dma_writeback.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dma_writeback.sv
// dma_writeback: write-back DMA engine.
//
// Buffers the accelerator result stream in a small FIFO and writes it to
// DRAM as Wishbone write bursts of up to BURST words. The CPU programs the
// engine through three CSRs and polls DONE or waits for the interrupt.
//
// CSR map (offsets from CSR_BASE, 16-byte window):
//   0x00 CTRL : bit0 START (write-1 pulse), bit1 DONE (write-1 clear),
//               bit2 BUSY (read-only)
//   0x04 DST  : destination byte address, bits[1:0] read back as 0
//   0x08 LEN  : word count, bits[15:0]
//   0x0C      : reads 0, writes ignored
//
// Ports:
//   wb_clk_i, wb_rst_i               clock, synchronous active-high reset
//   cpu_wbs_*                        CSR slave (sel ignored, full-word only)
//   acc_data_valid_i, acc_data_i     accelerator result stream
//   acc_ready_o                      engine accepts a word this cycle
//   dram_wbs_*, dram_burst_en_o      DRAM write master and burst qualifier
//   irq_o                            one-cycle transfer-complete pulse
//
// Build option: define DMA_WB_IRQ_EN to enable irq_o; otherwise irq_o is
// tied low and software polls CTRL.DONE.
//
// Handshakes: an accelerator word transfers on a clock edge where
// acc_data_valid_i and acc_ready_o are both high; a DRAM word completes on
// an edge where stb is high and dram_wbs_ack_i is high, and stb/adr/dat hold
// until that edge; a CSR access is acknowledged for one cycle, the cycle
// after stb&cyc with an in-window address is first seen.

module dma_writeback #(
    parameter int          DATA_WIDTH = 32,
    parameter int          DEPTH      = 4,
    parameter int          BURST      = 4,
    parameter logic [31:0] CSR_BASE   = 32'h3000_8000
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  cpu_wbs_stb_i,
    input  logic                  cpu_wbs_cyc_i,
    input  logic                  cpu_wbs_we_i,
    input  logic [3:0]            cpu_wbs_sel_i,
    input  logic [31:0]           cpu_wbs_adr_i,
    input  logic [31:0]           cpu_wbs_dat_i,
    output logic                  cpu_wbs_ack_o,
    output logic [31:0]           cpu_wbs_dat_o,
    input  logic                  acc_data_valid_i,
    input  logic [DATA_WIDTH-1:0] acc_data_i,
    output logic                  acc_ready_o,
    output logic                  dram_wbs_cyc_o,
    output logic                  dram_wbs_stb_o,
    output logic                  dram_wbs_we_o,
    output logic [3:0]            dram_wbs_sel_o,
    output logic [31:0]           dram_wbs_adr_o,
    output logic [31:0]           dram_wbs_dat_o,
    output logic                  dram_burst_en_o,
    input  logic                  dram_wbs_ack_i,
    output logic                  irq_o
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          LW      = AW + 1;
    localparam logic [15:0] BURST16 = 16'(BURST);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_ack;
    logic [31:0]           r_rdata;
    logic [31:0]           r_dst;
    logic [15:0]           r_len;
    logic [31:0]           r_addr;
    logic [15:0]           r_remaining;   // words still to be written to DRAM
    logic [15:0]           r_to_accept;   // words still to be taken from the accelerator
    logic [15:0]           r_beat;
    logic [15:0]           r_burst_len;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;

    logic        w_in_window;
    logic        w_csr_hit;
    logic        w_csr_wr;
    logic [1:0]  w_off;
    logic        w_start;
    logic        w_done_clr;
    logic        w_in_burst;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic [15:0] w_need;
    logic [31:0] w_rd_mux;
    logic        w_unused;

    assign w_in_window = (cpu_wbs_adr_i[31:4] == CSR_BASE[31:4]);
    // Blocking the hit while r_ack is high keeps ack to a single cycle even
    // if the master leaves stb asserted through the ack cycle.
    assign w_csr_hit   = cpu_wbs_cyc_i & cpu_wbs_stb_i & w_in_window & ~r_ack;
    assign w_csr_wr    = w_csr_hit & cpu_wbs_we_i;
    assign w_off       = cpu_wbs_adr_i[3:2];
    assign w_start     = w_csr_wr && (w_off == 2'd0) && cpu_wbs_dat_i[0];
    assign w_done_clr  = w_csr_wr && (w_off == 2'd0) && cpu_wbs_dat_i[1];

    assign w_in_burst  = (r_state == S_BURST);
    assign w_full      = (r_level == LW'(DEPTH));
    assign w_push      = acc_data_valid_i & acc_ready_o;
    assign w_pop       = w_in_burst & dram_wbs_ack_i;
    assign w_need      = (r_remaining < BURST16) ? r_remaining : BURST16;

    assign w_unused    = &{1'b0, cpu_wbs_sel_i, cpu_wbs_adr_i[1:0]};

    always_comb begin
        w_rd_mux = 32'd0;
        case (w_off)
            2'd0:    w_rd_mux = {29'd0, r_busy, r_done, 1'b0};
            2'd1:    w_rd_mux = r_dst;
            2'd2:    w_rd_mux = {16'd0, r_len};
            default: w_rd_mux = 32'd0;
        endcase
    end

    assign acc_ready_o     = r_busy && !w_full && (r_to_accept != 16'd0);

    assign cpu_wbs_ack_o   = r_ack;
    assign cpu_wbs_dat_o   = r_rdata;

    // DRAM outputs are forced low outside a burst so idle and reset show 0.
    assign dram_wbs_cyc_o  = w_in_burst;
    assign dram_wbs_stb_o  = w_in_burst;
    assign dram_wbs_we_o   = w_in_burst;
    assign dram_burst_en_o = w_in_burst;
    assign dram_wbs_sel_o  = w_in_burst ? 4'hF : 4'h0;
    assign dram_wbs_adr_o  = w_in_burst ? r_addr : 32'd0;
    assign dram_wbs_dat_o  = w_in_burst ? 32'(r_mem[r_rd_ptr]) : 32'd0;

    // FIFO storage carries no reset; the pointers and level define validity.
    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= acc_data_i;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ack       <= 1'b0;
            r_rdata     <= 32'd0;
            r_dst       <= 32'd0;
            r_len       <= 16'd0;
            r_addr      <= 32'd0;
            r_remaining <= 16'd0;
            r_to_accept <= 16'd0;
            r_beat      <= 16'd0;
            r_burst_len <= 16'd0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
        end else begin
            r_ack   <= w_csr_hit;
            r_rdata <= (w_csr_hit && !cpu_wbs_we_i) ? w_rd_mux : 32'd0;

            if (w_csr_wr && (w_off == 2'd1)) begin
                r_dst <= {cpu_wbs_dat_i[31:2], 2'b00};
            end
            if (w_csr_wr && (w_off == 2'd2)) begin
                r_len <= cpu_wbs_dat_i[15:0];
            end
            if (w_done_clr) begin
                r_done <= 1'b0;
            end

            if (w_push) begin
                r_wr_ptr    <= r_wr_ptr + 1'b1;
                r_to_accept <= r_to_accept - 16'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= r_level + LW'(w_push) - LW'(w_pop);

            case (r_state)
                S_IDLE: begin
                    // START is only honoured here, so a START while BUSY is dropped.
                    if (w_start) begin
                        if (r_len != 16'd0) begin
                            r_state     <= S_FILL;
                            r_addr      <= r_dst;
                            r_remaining <= r_len;
                            r_to_accept <= r_len;
                            r_busy      <= 1'b1;
                            r_done      <= 1'b0;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_FILL: begin
                    if (16'(r_level) >= w_need) begin
                        r_state     <= S_BURST;
                        r_beat      <= 16'd0;
                        r_burst_len <= w_need;
                    end
                end
                S_BURST: begin
                    if (dram_wbs_ack_i) begin
                        r_addr      <= r_addr + 32'd4;
                        r_remaining <= r_remaining - 16'd1;
                        r_beat      <= r_beat + 16'd1;
                        if (r_beat == r_burst_len - 16'd1) begin
                            // Going through FILL guarantees cyc drops between bursts.
                            r_state <= (r_remaining == 16'd1) ? S_DONE : S_FILL;
                        end
                    end
                end
                default: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DMA_WB_IRQ_EN
    logic r_irq;

    // Rises on the same edge that sets DONE.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (r_state == S_DONE);
        end
    end

    assign irq_o = r_irq;
`else
    assign irq_o = 1'b0;
`endif

endmodule
